// File: rtl/emb_argmax_pkg.sv
// Shared constants and types for the argmax tail that turns per-position logits
// back into packed character IDs.
package emb_argmax_pkg;

   localparam int N        = 10;
   localparam int CHAR_NUM = 200;
   localparam int CHAR_LEN = 8;
   localparam int N_LEN    = 16;
   localparam int CNT_W    = $clog2(CHAR_NUM);

   typedef logic signed [N_LEN-1:0] logit_t;
   typedef logic [CNT_W-1:0]        cnt_t;
   typedef logic [CHAR_LEN-1:0]     id_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/emb_argmax_if.sv
// Logit-column stream in, packed argmax IDs out; the datapath drives master,
// emb_argmax sits on slave.
interface emb_argmax_if;
   import emb_argmax_pkg::*;

   logic                  run;
   logic                  d_valid;
   logic [N*N_LEN-1:0]    d;
   logic                  d_ready;
   logic                  valid;
   logic [N*CHAR_LEN-1:0] q;

   modport master (output run, d_valid, d, input d_ready, valid, q);
   modport slave  (input run, d_valid, d, output d_ready, valid, q);

endinterface

// File: rtl/emb_argmax_lane.sv
// One position's running signed maximum and the candidate index that set it.
module emb_argmax_lane
   import emb_argmax_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   i_clear,
   input  logic   i_en,
   input  logit_t i_logit,
   input  cnt_t   i_cnt,
   output id_t    o_idx
);

   logit_t r_max;
   cnt_t   r_idx;
   logic   w_take;

   // Strict compare keeps the earliest candidate on ties.
   assign w_take = i_en && (i_clear || (i_logit > r_max));

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_max <= '0;
         r_idx <= '0;
      end else if (w_take) begin
         r_max <= i_logit;
         r_idx <= i_cnt;
      end
   end

   // Exposes the index including this cycle's beat, so the top can capture the
   // final result on the same edge as the last accepted beat.
   assign o_idx = id_t'(w_take ? i_cnt : r_idx);

endmodule

// File: rtl/emb_argmax.sv
// Scans CHAR_NUM logit columns and emits the per-position argmax as packed IDs,
// one cycle after the last accepted beat.
module emb_argmax
   import emb_argmax_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   emb_argmax_if.slave  bus
);

   state_t                r_state;
   state_t                w_state_nxt;
   cnt_t                  r_cnt;
   logic [N*CHAR_LEN-1:0] r_q;
   logic [N*CHAR_LEN-1:0] w_q_nxt;
   logic                  w_d_ready;
   logic                  w_valid;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_start;

   assign w_accept = bus.d_valid && w_d_ready;
   assign w_last   = w_accept && (r_cnt == cnt_t'(CHAR_NUM - 1));
   assign w_start  = bus.run && (r_state != S_SCAN);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // NOTE: default assignment first so no path through the case infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (bus.run) w_state_nxt = S_SCAN;
         S_SCAN:         if (w_last)  w_state_nxt = S_DONE;
         default:        w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_d_ready = (r_state == S_SCAN);
      w_valid   = (r_state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst)           r_cnt <= '0;
      else if (w_start)  r_cnt <= '0;
      else if (w_last)   r_cnt <= '0;
      else if (w_accept) r_cnt <= r_cnt + cnt_t'(1);
   end

   // q holds the previous result through a new scan until that scan completes.
   always_ff @(posedge clk) begin
      if (rst)         r_q <= '0;
      else if (w_last) r_q <= w_q_nxt;
   end

   for (genvar g = 0; g < N; g++) begin : g_lane
      emb_argmax_lane u_lane (
         .clk     (clk),
         .rst     (rst),
         .i_clear (r_cnt == '0),
         .i_en    (w_accept),
         .i_logit (bus.d[g*N_LEN +: N_LEN]),
         .i_cnt   (r_cnt),
         .o_idx   (w_q_nxt[g*CHAR_LEN +: CHAR_LEN])
      );
   end

   assign bus.d_ready = w_d_ready;
   assign bus.valid   = w_valid;
   assign bus.q       = r_q;

endmodule

// File: doc/emb_argmax.md
Name: emb_argmax

Overview:
- Inverse of the embedding front end: converts per-position output logits back into character IDs.
- Accepts a stream of logit columns, one candidate character per beat, carrying the logits of all `N` positions.
- Tracks a running signed maximum per position and emits `N` packed `CHAR_LEN`-bit IDs.
- Sits at the tail of the trained datapath, after the final dense layer, producing the `q` bus in the same packed ID format the embedding layer consumes on `d`.

Parameters:
- N, 10, number of character positions (matches `N).
- CHAR_NUM, 200, number of candidate characters, i.e. beats per scan.
- CHAR_LEN, 8, width of one character ID; must satisfy 2^CHAR_LEN >= CHAR_NUM.
- N_LEN, 16, width of one signed two's-complement logit (matches `N_LEN).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  one-cycle start pulse; begins a new scan.
- d_valid  in  1  logit column on d is valid.
- d  in  N*N_LEN  logits of current candidate; position i at d[i*N_LEN +: N_LEN], signed.
- d_ready  out  1  block accepts a beat this cycle.
- valid  out  1  q holds a complete result.
- q  out  N*CHAR_LEN  argmax IDs; position i at q[i*CHAR_LEN +: CHAR_LEN].

Behaviour:
- Reset (rst=1 at a clock edge, any state):
  - state=IDLE, cnt=0, d_ready=0, valid=0, q=0.
  - All lane max/idx registers cleared.
  - Overrides run and d_valid in the same cycle.
- FSM states are IDLE, SCAN and DONE.
- IDLE / DONE transitions:
  - run=1 -> SCAN next cycle: cnt=0, valid=0.
  - q keeps its previous value until the new scan completes.
- SCAN:
  - d_ready=1 (combinational from state).
  - A beat is accepted when d_valid & d_ready.
  - On each accepted beat, each lane i:
    - if cnt==0 or signed(d_i) > max_i (strictly greater): max_i<=d_i, idx_i<=cnt.
    - cnt<=cnt+1.
- Ties: the lowest candidate index wins (strict compare).
- Beat with d_valid=0: no state change, cnt holds; gaps of any length are allowed.
- Last beat (cnt==CHAR_NUM-1 accepted):
  - Next cycle: state=DONE, valid=1, q loaded from the final idx values, including the last beat's update.
  - Latency is one cycle after the last accepted beat.
- DONE: valid stays 1 and q stays stable until the next run or rst.
- run while in SCAN is ignored; the scan continues unchanged.
- d_valid outside SCAN is ignored, with d_ready=0.
- run and last beat in the same cycle: run is ignored and DONE is entered normally.
- cnt width is $clog2(CHAR_NUM); cnt never wraps, because the transition fires at CHAR_NUM-1.
- All comparisons are full N_LEN-bit signed; no saturation or truncation is required.

Decomposition:
- Shared header consts_trained.vh already supplies `N, `N_LEN, `CHAR_LEN; add `CHAR_NUM there.
- FSM state encodings are local parameters.
- One sub-module, emb_argmax_lane, instantiated N times in a generate loop:
  - inputs: clk, rst, clear (first beat), en (accepted beat), logit, cnt.
  - state: max and idx registers, one signed comparator.
  - output: idx.
- Top level holds the FSM, cnt, the q output register and the bus slicing.

Test Plan:
- Reset: hold rst 2 cycles with run=1 and d_valid=1 -> valid=0, d_ready=0, q=0; no scan starts.
- One-hot: lane i logit=100 at k=7*i, -5 elsewhere, d_valid held high for 200 beats -> valid=1 exactly one cycle after beat 199; q_i=7*i; q stable for 20 further cycles.
- Ties: all logits 0 -> q all 0. Lane 0 logit=50 at k=3 and at k=150 -> q_0=3.
- Signed compare: all logits 16'h8000 except lane 5 = -1 (16'hFFFF) at k=199 -> q_5=199, other lanes 0.
- Gaps: d_valid randomly deasserted for about 30% of cycles with the one-hot stimulus -> same q as the gap-free run; valid only after the 200th accepted beat.
- Mid-scan reset and run: rst at beat 100 -> IDLE, valid=0, q=0; a second run pulse during a later SCAN is ignored (result identical); run in DONE -> valid drops next cycle, old q held, new q appears after 200 beats.
